// File: rtl/imem_arbiter.sv
// imem_arbiter: shares one Imem read port between fetch (F) and loader (L).
// Define IMEM_ARB_RR_EN for round-robin; otherwise F has fixed priority.
module imem_arbiter #(
   parameter int unsigned ADDRESS_SIZE = 32,
   parameter logic [0:ADDRESS_SIZE-1] BOOT_ADDRESS = 32'h1000,
   parameter int unsigned MEM_LATENCY = 2
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic                    f_req_valid,
   input  logic [0:ADDRESS_SIZE-1] f_req_address,
   output logic                    f_req_ready,
   output logic                    f_resp_valid,
   input  logic                    f_resp_ready,
   output logic [0:ADDRESS_SIZE-1] f_resp_instruction,
   output logic                    f_resp_err,
   input  logic                    l_req_valid,
   input  logic [0:ADDRESS_SIZE-1] l_req_address,
   output logic                    l_req_ready,
   output logic                    l_resp_valid,
   input  logic                    l_resp_ready,
   output logic [0:ADDRESS_SIZE-1] l_resp_instruction,
   output logic                    l_resp_err,
   output logic [0:ADDRESS_SIZE-1] mem_address,
   input  logic [0:ADDRESS_SIZE-1] mem_instruction,
   output logic                    busy
);

   localparam int CW = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(MEM_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t                  state_q, state_d;
   logic [CW-1:0]           cnt_q, cnt_d;
   logic                    gnt_l_q, gnt_l_d;
   logic [0:ADDRESS_SIZE-1] addr_q, addr_d;
   logic [0:ADDRESS_SIZE-1] f_data_q, f_data_d;
   logic [0:ADDRESS_SIZE-1] l_data_q, l_data_d;
   logic                    f_err_q, f_err_d;
   logic                    l_err_q, l_err_d;

   logic                    any_req;
   logic                    pick_l;
   logic                    grant;
   logic                    sel_mis;
   logic [0:ADDRESS_SIZE-1] sel_addr;

`ifdef IMEM_ARB_RR_EN
   // rr_l_q remembers the last granted port (1 = L)
   logic rr_l_q, rr_l_d;
   always_comb pick_l = l_req_valid & (~f_req_valid | ~rr_l_q);
`else
   always_comb pick_l = l_req_valid & ~f_req_valid;
`endif

   always_comb begin
      any_req  = f_req_valid | l_req_valid;
      grant    = reset & (state_q == IDLE) & any_req;
      sel_addr = pick_l ? l_req_address : f_req_address;
      sel_mis  = |sel_addr[ADDRESS_SIZE-2:ADDRESS_SIZE-1];
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      gnt_l_d  = gnt_l_q;
      addr_d   = addr_q;
      f_data_d = f_data_q;
      l_data_d = l_data_q;
      f_err_d  = f_err_q;
      l_err_d  = l_err_q;
`ifdef IMEM_ARB_RR_EN
      rr_l_d   = rr_l_q;
`endif
      case (state_q)
         IDLE: begin
            if (any_req) begin
               gnt_l_d = pick_l;
`ifdef IMEM_ARB_RR_EN
               rr_l_d  = pick_l;
`endif
               if (sel_mis) begin
                  // misaligned: answer at once, Imem untouched
                  state_d = RESP;
                  if (pick_l) begin
                     l_data_d = '0;
                     l_err_d  = 1'b1;
                  end else begin
                     f_data_d = '0;
                     f_err_d  = 1'b1;
                  end
               end else begin
                  state_d = BUSY;
                  addr_d  = sel_addr;
                  cnt_d   = '0;
               end
            end
         end
         BUSY: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_LAST) begin
               state_d = RESP;
               if (gnt_l_q) begin
                  l_data_d = mem_instruction;
                  l_err_d  = 1'b0;
               end else begin
                  f_data_d = mem_instruction;
                  f_err_d  = 1'b0;
               end
            end
         end
         RESP: begin
            if (gnt_l_q ? l_resp_ready : f_resp_ready)
               state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         gnt_l_q  <= 1'b0;
         addr_q   <= BOOT_ADDRESS;
         f_data_q <= '0;
         l_data_q <= '0;
         f_err_q  <= 1'b0;
         l_err_q  <= 1'b0;
`ifdef IMEM_ARB_RR_EN
         rr_l_q   <= 1'b1;
`endif
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         gnt_l_q  <= gnt_l_d;
         addr_q   <= addr_d;
         f_data_q <= f_data_d;
         l_data_q <= l_data_d;
         f_err_q  <= f_err_d;
         l_err_q  <= l_err_d;
`ifdef IMEM_ARB_RR_EN
         rr_l_q   <= rr_l_d;
`endif
      end
   end

   always_comb begin
      f_req_ready        = grant & ~pick_l;
      l_req_ready        = grant & pick_l;
      f_resp_valid       = (state_q == RESP) & ~gnt_l_q;
      l_resp_valid       = (state_q == RESP) & gnt_l_q;
      f_resp_instruction = f_data_q;
      l_resp_instruction = l_data_q;
      f_resp_err         = f_err_q;
      l_resp_err         = l_err_q;
      mem_address        = addr_q;
      busy               = (state_q != IDLE);
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// tb_imem_arbiter: randomized scoreboard bench for imem_arbiter.
// Follows IMEM_ARB_RR_EN to pick the expected arbitration policy.
module tb_imem_arbiter;

   localparam int LAT = 2;
   localparam logic [31:0] BOOT = 32'h1000;

   typedef struct {
      logic [31:0] data;
      logic        err;
      logic [31:0] maddr;
      int          due;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        f_req_valid = 1'b0;
   logic [31:0] f_req_address = '0;
   logic        f_req_ready;
   logic        f_resp_valid;
   logic        f_resp_ready = 1'b0;
   logic [31:0] f_resp_instruction;
   logic        f_resp_err;
   logic        l_req_valid = 1'b0;
   logic [31:0] l_req_address = '0;
   logic        l_req_ready;
   logic        l_resp_valid;
   logic        l_resp_ready = 1'b0;
   logic [31:0] l_resp_instruction;
   logic        l_resp_err;
   logic [31:0] mem_address;
   logic [31:0] mem_instruction;
   logic        busy;

   exp_t qf[$];
   exp_t ql[$];
   logic grants[$];
   int   vec = 0;
   int   mis = 0;
   int   cyc = 0;
   int   new_pct_f = 0, new_pct_l = 0;
   int   rdy_pct_f = 100, rdy_pct_l = 100;
   logic last_l = 1'b1;
   logic f_acc = 1'b0, l_acc = 1'b0;
   bit   seen[2];
   bit   held[2];

   imem_arbiter #(
      .ADDRESS_SIZE(32),
      .BOOT_ADDRESS(BOOT),
      .MEM_LATENCY(LAT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .f_req_valid(f_req_valid),
      .f_req_address(f_req_address),
      .f_req_ready(f_req_ready),
      .f_resp_valid(f_resp_valid),
      .f_resp_ready(f_resp_ready),
      .f_resp_instruction(f_resp_instruction),
      .f_resp_err(f_resp_err),
      .l_req_valid(l_req_valid),
      .l_req_address(l_req_address),
      .l_req_ready(l_req_ready),
      .l_resp_valid(l_resp_valid),
      .l_resp_ready(l_resp_ready),
      .l_resp_instruction(l_resp_instruction),
      .l_resp_err(l_resp_err),
      .mem_address(mem_address),
      .mem_instruction(mem_instruction),
      .busy(busy)
   );

   function automatic logic [31:0] word(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
   endfunction

   assign mem_instruction = word(mem_address);

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = BOOT + ($urandom_range(0, 255) << 2);
      if ($urandom_range(0, 3) == 0)
         a[1:0] = 2'($urandom_range(1, 3));
      return a;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      vec++;
      if (act !== exp) begin
         mis++;
         $display("FAIL %s: got %h expected %h (cycle %0d)",
                  nm, act, exp, cyc);
      end
   endtask

   // one requester/consumer cycle: drive at negedge, sample 1 ns later
   task automatic step();
      logic fv, lv, fr, lr, g, exp_l;
      logic [31:0] a;
      exp_t e;
      @(negedge clk);
      if (f_acc) begin f_req_valid = 1'b0; f_acc = 1'b0; end
      if (l_acc) begin l_req_valid = 1'b0; l_acc = 1'b0; end
      if (!f_req_valid && $urandom_range(0, 99) < new_pct_f) begin
         f_req_address = rand_addr();
         f_req_valid = 1'b1;
      end
      if (!l_req_valid && $urandom_range(0, 99) < new_pct_l) begin
         l_req_address = rand_addr();
         l_req_valid = 1'b1;
      end
      f_resp_ready = ($urandom_range(0, 99) < rdy_pct_f);
      l_resp_ready = ($urandom_range(0, 99) < rdy_pct_l);
      #1;
      fv = f_req_valid; lv = l_req_valid;
      fr = f_req_ready; lr = l_req_ready;
      if (fr || lr) begin
         chk("ready_onehot", 32'(fr & lr), 0);
         chk("ready_needs_valid", 32'((fr & ~fv) | (lr & ~lv)), 0);
         chk("ready_only_idle", 32'(busy | f_resp_valid | l_resp_valid), 0);
`ifdef IMEM_ARB_RR_EN
         exp_l = ~last_l;
`else
         exp_l = 1'b0;
`endif
         if (fv && lv) chk("winner", 32'(lr), 32'(exp_l));
         g = lr;
         last_l = g;
         grants.push_back(g);
         a = g ? l_req_address : f_req_address;
         e.err   = |a[1:0];
         e.data  = e.err ? 32'h0 : word(a);
         e.maddr = e.err ? mem_address : a;
         e.due   = cyc + (e.err ? 1 : LAT + 1);
         if (g) begin ql.push_back(e); l_acc = 1'b1; end
         else begin qf.push_back(e); f_acc = 1'b1; end
      end else if (!busy && (fv || lv)) begin
         chk("idle_grant", 32'(fr | lr), 1);
      end
   endtask

   task automatic mon(input int p);
      logic v, r, e, ov;
      logic [31:0] d;
      exp_t ex;
      v  = p ? l_resp_valid : f_resp_valid;
      r  = p ? l_resp_ready : f_resp_ready;
      d  = p ? l_resp_instruction : f_resp_instruction;
      e  = p ? l_resp_err : f_resp_err;
      ov = p ? f_resp_valid : l_resp_valid;
      if (held[p]) chk("valid_held", 32'(v), 1);
      if (v) begin
         if ((p ? ql.size() : qf.size()) == 0) begin
            chk("unexpected_resp", 32'(v), 0);
         end else begin
            ex = p ? ql[0] : qf[0];
            if (!seen[p]) begin
               chk("latency", cyc, ex.due);
               seen[p] = 1'b1;
            end
            chk(p ? "l_data" : "f_data", d, ex.data);
            chk(p ? "l_err" : "f_err", 32'(e), 32'(ex.err));
            chk("mem_addr_at_resp", mem_address, ex.maddr);
            chk("other_valid_low", 32'(ov), 0);
            if (r) begin
               if (p) void'(ql.pop_front());
               else void'(qf.pop_front());
               seen[p] = 1'b0;
            end
         end
      end
      held[p] = v & ~r;
   endtask

   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (!reset) begin
            held[0] = 1'b0;
            held[1] = 1'b0;
         end else begin
            mon(0);
            mon(1);
         end
      end
   end

   task automatic drain();
      int n;
      new_pct_f = 0; new_pct_l = 0;
      rdy_pct_f = 100; rdy_pct_l = 100;
      n = 0;
      while ((f_req_valid || l_req_valid || qf.size() != 0 ||
              ql.size() != 0 || busy) && n < 200) begin
         step();
         n++;
      end
      if (n >= 200) chk("drain_timeout", 32'(busy), 0);
   endtask

   initial begin
      int n;
      // reset: ready must stay low even with a request present
      f_req_valid = 1'b1;
      f_req_address = 32'h1004;
      repeat (3) @(negedge clk);
      #1;
      chk("rst_mem_address", mem_address, BOOT);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_f_req_ready", 32'(f_req_ready), 0);
      chk("rst_valids", 32'({f_resp_valid, l_resp_valid}), 0);
      chk("rst_errs", 32'({f_resp_err, l_resp_err}), 0);
      chk("rst_data", f_resp_instruction | l_resp_instruction, 0);
      f_req_valid = 1'b0;
      reset = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      chk("idle_mem_address", mem_address, BOOT);
      chk("idle_busy", 32'(busy), 0);
      chk("idle_readys", 32'({f_req_ready, l_req_ready}), 0);

      // both requesters valid continuously: record grant order
      new_pct_f = 100; new_pct_l = 100;
      n = 0;
      while (grants.size() < 4 && n < 100) begin step(); n++; end
      for (int k = 0; k < 4; k++) begin
`ifdef IMEM_ARB_RR_EN
         chk($sformatf("grant_order_%0d", k),
             32'(k < grants.size() ? grants[k] : 1'bx), 32'(k % 2));
`else
         chk($sformatf("grant_order_%0d", k),
             32'(k < grants.size() ? grants[k] : 1'bx), 0);
`endif
      end
      drain();

      // F response stalled while L waits
      rdy_pct_f = 0; rdy_pct_l = 100;
      new_pct_f = 100; step();
      new_pct_f = 0; new_pct_l = 100; step();
      new_pct_l = 0;
      repeat (LAT + 6) step();
      chk("stall_f_valid", 32'(f_resp_valid), 1);
      chk("stall_l_not_granted", ql.size(), 0);
      drain();

      // randomized traffic
      new_pct_f = 50; new_pct_l = 40;
      rdy_pct_f = 70; rdy_pct_l = 60;
      repeat (2000) step();
      drain();

      // reset in the middle of an access
      @(negedge clk);
      f_req_address = 32'h1100;
      f_req_valid = 1'b1;
      #1;
      chk("abort_accept", 32'(f_req_ready), 1);
      @(negedge clk);
      f_req_valid = 1'b0;
      chk("abort_busy_before", 32'(busy), 1);
      reset = 1'b0;
      #1;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_mem_address", mem_address, BOOT);
      chk("abort_valids", 32'({f_resp_valid, l_resp_valid}), 0);
      chk("abort_readys", 32'({f_req_ready, l_req_ready}), 0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      last_l = 1'b1;
      new_pct_f = 0; new_pct_l = 0;
      repeat (10) step();
      chk("abort_no_resp_busy", 32'(busy), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vec, mis);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
